snn_seq_ctrl: RTL and testbench

Host-side sequencer for the SNN core. Accepts a run command (mode, label, image count), optionally streams pretrained weights, then feeds each image word-by-word into the core, waits for the core's classification, and reports per-image results and a running correct-count. Sits between the testbench/host stream sources and the SNN core's start/image/weight/result ports.

---
 rtl/snn_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_snn_seq_ctrl.sv | 552 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_seq_ctrl.sv
// snn_seq_ctrl: host-side sequencer for the SNN core.
// Takes a run command, optionally streams weights, then feeds images word by
// word into the core, collects each classification and keeps a correct count.
module snn_seq_ctrl #(
    parameter int unsigned IMG_WORDS   = 25,
    parameter int unsigned WT_WORDS    = 64,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_mode,
    input  logic [7:0]  cmd_label,
    input  logic [15:0] cmd_count,

    input  logic [31:0] img_data,
    input  logic        img_valid,
    output logic        img_ready,

    input  logic [31:0] wt_data,
    input  logic        wt_valid,
    output logic        wt_ready,

    output logic        core_start_main,
    output logic [1:0]  core_mode,
    output logic [7:0]  core_test_label,
    output logic [31:0] core_image_in,
    output logic [31:0] core_weight_in,
    output logic        core_valid_image,
    input  logic        core_ready,
    input  logic        core_start_core_img,
    input  logic        core_valid_all,
    input  logic [7:0]  core_image_label,

    output logic        res_valid,
    output logic [7:0]  res_label,
    output logic        res_match,
    output logic [15:0] res_index,
    output logic [15:0] correct_cnt,

    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic        err_mode
);

    localparam int unsigned MAX_WORDS = (IMG_WORDS > WT_WORDS) ? IMG_WORDS : WT_WORDS;
    localparam int unsigned WC_W      = $clog2(MAX_WORDS + 1);
    localparam int unsigned TC_W      = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] MODE_TEST     = 2'd1;
    localparam logic [1:0] MODE_CLASSIFY = 2'd2;
    localparam logic [1:0] MODE_RSVD     = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WLOAD,
        S_WAIT_IMG,
        S_ILOAD,
        S_WAIT_RES,
        S_REPORT,
        S_FINISH
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [1:0]        mode_q;
    logic [7:0]        label_q;
    logic [15:0]       count_q;
    logic [15:0]       img_cnt_q;
    logic [WC_W-1:0]   word_cnt_q;
    logic [TC_W-1:0]   tmo_cnt_q;
    logic [7:0]        res_label_q;
    logic              res_match_q;
    logic [15:0]       res_index_q;
    logic [15:0]       correct_cnt_q;
    logic              err_timeout_q;
    logic              err_mode_q;

    logic              accept;
    logic              wt_xfer;
    logic              img_xfer;
    logic              capture;
    logic              tmo_hit;
    logic              in_wait;
    logic              tmo_expired;
    logic              match_c;

    // The TIMEOUT_CYC-th consecutive idle cycle in a wait state is the last one
    assign tmo_expired = (tmo_cnt_q == TC_W'(TIMEOUT_CYC - 1));
    assign match_c     = (mode_q == MODE_TEST) && (core_image_label == label_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode, stream pass-through and control strobes
    always_comb begin
        state_d          = state_q;
        cmd_ready        = 1'b0;
        img_ready        = 1'b0;
        wt_ready         = 1'b0;
        core_valid_image = 1'b0;
        core_image_in    = 32'd0;
        core_weight_in   = 32'd0;
        core_start_main  = 1'b0;
        res_valid        = 1'b0;
        done             = 1'b0;
        busy             = 1'b1;
        accept           = 1'b0;
        wt_xfer          = 1'b0;
        img_xfer         = 1'b0;
        capture          = 1'b0;
        tmo_hit          = 1'b0;
        in_wait          = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept = 1'b1;
                    if ((cmd_count == 16'd0) || (cmd_mode == MODE_RSVD)) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_START;
                    end
                end
            end

            S_START: begin
                core_start_main = 1'b1;
                state_d = (mode_q == MODE_CLASSIFY) ? S_WLOAD : S_WAIT_IMG;
            end

            S_WLOAD: begin
                in_wait        = 1'b1;
                core_weight_in = wt_data;
                wt_ready       = core_ready;
                wt_xfer        = wt_valid && core_ready;
                if (wt_xfer) begin
                    if (word_cnt_q == WC_W'(WT_WORDS - 1)) begin
                        state_d = S_WAIT_IMG;
                    end
                end else if (tmo_expired) begin
                    tmo_hit = 1'b1;
                    state_d = S_FINISH;
                end
            end

            S_WAIT_IMG: begin
                in_wait = 1'b1;
                if (core_start_core_img) begin
                    state_d = S_ILOAD;
                end else if (tmo_expired) begin
                    tmo_hit = 1'b1;
                    state_d = S_FINISH;
                end
            end

            S_ILOAD: begin
                in_wait          = 1'b1;
                core_image_in    = img_data;
                img_ready        = core_ready;
                img_xfer         = img_valid && core_ready;
                core_valid_image = img_xfer;
                if (img_xfer) begin
                    if (word_cnt_q == WC_W'(IMG_WORDS - 1)) begin
                        state_d = S_WAIT_RES;
                    end
                end else if (tmo_expired) begin
                    tmo_hit = 1'b1;
                    state_d = S_FINISH;
                end
            end

            S_WAIT_RES: begin
                in_wait = 1'b1;
                // A result arriving on the expiry cycle still counts
                if (core_valid_all) begin
                    capture = 1'b1;
                    state_d = S_REPORT;
                end else if (tmo_expired) begin
                    tmo_hit = 1'b1;
                    state_d = S_FINISH;
                end
            end

            S_REPORT: begin
                res_valid = 1'b1;
                state_d = ((img_cnt_q + 16'd1) == count_q) ? S_FINISH : S_WAIT_IMG;
            end

            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Word and timeout counters; both restart on any state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            if (state_d != state_q) begin
                word_cnt_q <= '0;
            end else if (wt_xfer || img_xfer) begin
                word_cnt_q <= word_cnt_q + WC_W'(1);
            end

            if ((state_d != state_q) || wt_xfer || img_xfer) begin
                tmo_cnt_q <= '0;
            end else if (in_wait) begin
                tmo_cnt_q <= tmo_cnt_q + TC_W'(1);
            end
        end
    end

    // Command latch, result capture, run statistics and sticky errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q        <= 2'd0;
            label_q       <= 8'd0;
            count_q       <= 16'd0;
            img_cnt_q     <= 16'd0;
            res_label_q   <= 8'd0;
            res_match_q   <= 1'b0;
            res_index_q   <= 16'd0;
            correct_cnt_q <= 16'd0;
            err_timeout_q <= 1'b0;
            err_mode_q    <= 1'b0;
        end else begin
            if (accept) begin
                mode_q        <= cmd_mode;
                label_q       <= cmd_label;
                count_q       <= cmd_count;
                img_cnt_q     <= 16'd0;
                correct_cnt_q <= 16'd0;
                err_timeout_q <= 1'b0;
                err_mode_q    <= (cmd_mode == MODE_RSVD);
            end

            if (tmo_hit) begin
                err_timeout_q <= 1'b1;
            end

            if (capture) begin
                res_label_q <= core_image_label;
                res_match_q <= match_c;
                res_index_q <= img_cnt_q;
                if (match_c && (correct_cnt_q != 16'hFFFF)) begin
                    correct_cnt_q <= correct_cnt_q + 16'd1;
                end
            end

            if (state_q == S_REPORT) begin
                img_cnt_q <= img_cnt_q + 16'd1;
            end
        end
    end

    assign core_mode       = mode_q;
    assign core_test_label = label_q;
    assign res_label       = res_label_q;
    assign res_match       = res_match_q;
    assign res_index       = res_index_q;
    assign correct_cnt     = correct_cnt_q;
    assign err_timeout     = err_timeout_q;
    assign err_mode        = err_mode_q;

endmodule

// File: tb/tb_snn_seq_ctrl.sv
// Testbench for snn_seq_ctrl: acts as host stream source and as the SNN core.
module tb_snn_seq_ctrl;

    localparam int IMG_WORDS   = 25;
    localparam int WT_WORDS    = 64;
    localparam int TIMEOUT_CYC = 100;

    typedef struct {
        logic [7:0]  label;
        logic        match;
        logic [15:0] index;
    } res_t;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_mode;
    logic [7:0]  cmd_label;
    logic [15:0] cmd_count;
    logic [31:0] img_data;
    logic        img_valid;
    logic        img_ready;
    logic [31:0] wt_data;
    logic        wt_valid;
    logic        wt_ready;
    logic        core_start_main;
    logic [1:0]  core_mode;
    logic [7:0]  core_test_label;
    logic [31:0] core_image_in;
    logic [31:0] core_weight_in;
    logic        core_valid_image;
    logic        core_ready;
    logic        core_start_core_img;
    logic        core_valid_all;
    logic [7:0]  core_image_label;
    logic        res_valid;
    logic [7:0]  res_label;
    logic        res_match;
    logic [15:0] res_index;
    logic [15:0] correct_cnt;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic        err_mode;

    int total = 0;
    int bad   = 0;
    int done_cnt  = 0;
    int res_cnt   = 0;
    int start_cnt = 0;

    logic [31:0] exp_words[$];
    logic [31:0] got_words[$];
    res_t        exp_res[$];
    res_t        got_res[$];

    snn_seq_ctrl #(
        .IMG_WORDS   (IMG_WORDS),
        .WT_WORDS    (WT_WORDS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_mode            (cmd_mode),
        .cmd_label           (cmd_label),
        .cmd_count           (cmd_count),
        .img_data            (img_data),
        .img_valid           (img_valid),
        .img_ready           (img_ready),
        .wt_data             (wt_data),
        .wt_valid            (wt_valid),
        .wt_ready            (wt_ready),
        .core_start_main     (core_start_main),
        .core_mode           (core_mode),
        .core_test_label     (core_test_label),
        .core_image_in       (core_image_in),
        .core_weight_in      (core_weight_in),
        .core_valid_image    (core_valid_image),
        .core_ready          (core_ready),
        .core_start_core_img (core_start_core_img),
        .core_valid_all      (core_valid_all),
        .core_image_label    (core_image_label),
        .res_valid           (res_valid),
        .res_label           (res_label),
        .res_match           (res_match),
        .res_index           (res_index),
        .correct_cnt         (correct_cnt),
        .busy                (busy),
        .done                (done),
        .err_timeout         (err_timeout),
        .err_mode            (err_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (done)            done_cnt  <= done_cnt + 1;
        if (res_valid)       res_cnt   <= res_cnt + 1;
        if (core_start_main) start_cnt <= start_cnt + 1;
    end

    // Global time bound
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no checking) ----------------

    task automatic issue_cmd(input logic [1:0] m, input logic [7:0] l, input logic [15:0] c,
                             output bit rdy, output bit start_now);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_label = l;
        cmd_count = c;
        #1 rdy = cmd_ready;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1 start_now = core_start_main;
    endtask

    task automatic core_req_img();
        @(negedge clk);
        core_start_core_img = 1'b1;
        @(negedge clk);
        core_start_core_img = 1'b0;
    endtask

    // Host pushes each word it sees accepted; core side records what it receives
    task automatic stream(input bit is_wt, input int n, input bit bp,
                          output int xfers, output bit vi_bad);
        logic [31:0] w;
        int cyc;
        bit vld;
        xfers  = 0;
        vi_bad = 1'b0;
        cyc    = 0;
        w      = $urandom;
        while (xfers < n && cyc < 2000) begin
            @(negedge clk);
            core_ready = bp ? ~cyc[0] : 1'b1;
            vld = !(bp && ($urandom_range(0, 3) == 0));
            if (is_wt) begin
                wt_valid = vld;
                wt_data  = vld ? w : ~w;
            end else begin
                img_valid = vld;
                img_data  = vld ? w : ~w;
            end
            #1;
            if (is_wt) begin
                if (core_ready && wt_valid) got_words.push_back(core_weight_in);
                if (core_valid_image) vi_bad = 1'b1;
                if (wt_ready && wt_valid) begin
                    exp_words.push_back(w);
                    xfers++;
                    w = $urandom;
                end
            end else begin
                if (core_valid_image) got_words.push_back(core_image_in);
                if (img_ready && img_valid) begin
                    exp_words.push_back(w);
                    xfers++;
                    w = $urandom;
                end
            end
            cyc++;
        end
        @(negedge clk);
        img_valid  = 1'b0;
        wt_valid   = 1'b0;
        core_ready = 1'b1;
    endtask

    task automatic core_result(input logic [7:0] lbl, output bit got);
        res_t r;
        @(negedge clk);
        core_valid_all   = 1'b1;
        core_image_label = lbl;
        @(negedge clk);
        core_valid_all = 1'b0;
        #1;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            if (res_valid) begin
                got = 1'b1;
                r.label = res_label;
                r.match = res_match;
                r.index = res_index;
                got_res.push_back(r);
            end else begin
                @(negedge clk);
                #1;
            end
        end
    endtask

    task automatic score_words(output int n_exp, output int n_got, output int n_bad);
        n_exp = exp_words.size();
        n_got = got_words.size();
        n_bad = 0;
        while (exp_words.size() > 0 && got_words.size() > 0) begin
            if (exp_words.pop_front() !== got_words.pop_front()) n_bad++;
        end
        exp_words.delete();
        got_words.delete();
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
        total++;
        if ({busy, done, res_valid, core_start_main, img_ready, wt_ready, core_valid_image} !== 7'b0) begin
            bad++; $display("FAIL reset_ctrl_outputs: got %b want 0000000",
                {busy, done, res_valid, core_start_main, img_ready, wt_ready, core_valid_image});
        end
        total++;
        if ({err_timeout, err_mode, res_match} !== 3'b000) begin
            bad++; $display("FAIL reset_flags: got %b want 000", {err_timeout, err_mode, res_match});
        end
        total++;
        if ({correct_cnt, res_index, res_label} !== 40'd0) begin
            bad++; $display("FAIL reset_counters: got %h want 0", {correct_cnt, res_index, res_label});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if ({cmd_ready, busy} !== 2'b10) begin
            bad++; $display("FAIL reset_release_idle: got %b want 10", {cmd_ready, busy});
        end
    endtask

    task automatic test_test_run();
        logic [7:0] lbls [3];
        int d0, r0, xf, ne, ng, nb;
        bit rdy, st, got, vib;
        res_t e, g;
        lbls[0] = 8'd7; lbls[1] = 8'd3; lbls[2] = 8'd7;
        d0 = done_cnt;
        r0 = res_cnt;
        issue_cmd(2'd1, 8'd7, 16'd3, rdy, st);
        total++;
        if (rdy !== 1'b1) begin bad++; $display("FAIL run_cmd_ready: got %b want 1", rdy); end
        total++;
        if (st !== 1'b1) begin bad++; $display("FAIL run_start_main: got %b want 1", st); end
        total++;
        if ({core_mode, core_test_label} !== {2'd1, 8'd7}) begin
            bad++; $display("FAIL run_core_mode_label: got %h want %h", {core_mode, core_test_label}, {2'd1, 8'd7});
        end
        for (int i = 0; i < 3; i++) begin
            core_req_img();
            stream(1'b0, IMG_WORDS, 1'b0, xf, vib);
            score_words(ne, ng, nb);
            total++;
            if (xf != IMG_WORDS || ng != ne || nb != 0) begin
                bad++; $display("FAIL run_img_words[%0d]: got xfers=%0d rcv=%0d bad=%0d want %0d/%0d/0",
                    i, xf, ng, nb, IMG_WORDS, ne);
            end
            e.label = lbls[i];
            e.match = (lbls[i] == 8'd7);
            e.index = 16'(i);
            exp_res.push_back(e);
            core_result(lbls[i], got);
            total++;
            if (!got) begin bad++; $display("FAIL run_res_valid[%0d]: got none want pulse", i); end
        end
        @(negedge clk);
        #1;
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL run_done_timing: got %b want 1", done); end
        total++;
        if (correct_cnt !== 16'd2) begin bad++; $display("FAIL run_correct_cnt: got %0d want 2", correct_cnt); end
        while (exp_res.size() > 0) begin
            e = exp_res.pop_front();
            total++;
            if (got_res.size() == 0) begin
                bad++; $display("FAIL run_result: got none want %h/%b/%0d", e.label, e.match, e.index);
            end else begin
                g = got_res.pop_front();
                if ({g.label, g.match, g.index} !== {e.label, e.match, e.index}) begin
                    bad++; $display("FAIL run_result: got %h/%b/%0d want %h/%b/%0d",
                        g.label, g.match, g.index, e.label, e.match, e.index);
                end
            end
        end
        got_res.delete();
        @(negedge clk);
        #1;
        total++;
        if (done_cnt - d0 != 1 || res_cnt - r0 != 3 || busy !== 1'b0) begin
            bad++; $display("FAIL run_pulse_counts: got done=%0d res=%0d busy=%b want 1/3/0",
                done_cnt - d0, res_cnt - r0, busy);
        end
    endtask

    task automatic test_classify();
        int s0, xf, ne, ng, nb;
        bit rdy, st, got, vib;
        res_t g;
        s0 = start_cnt;
        issue_cmd(2'd2, 8'd0, 16'd1, rdy, st);
        total++;
        if (st !== 1'b1) begin bad++; $display("FAIL cls_start_main: got %b want 1", st); end
        stream(1'b1, WT_WORDS, 1'b0, xf, vib);
        score_words(ne, ng, nb);
        total++;
        if (xf != WT_WORDS || ng != ne || nb != 0) begin
            bad++; $display("FAIL cls_wt_words: got xfers=%0d rcv=%0d bad=%0d want %0d/%0d/0",
                xf, ng, nb, WT_WORDS, ne);
        end
        total++;
        if (vib !== 1'b0) begin bad++; $display("FAIL cls_valid_image_in_wload: got %b want 0", vib); end
        @(negedge clk);
        wt_valid = 1'b1;
        wt_data  = 32'h1234_5678;
        #1;
        total++;
        if (wt_ready !== 1'b0) begin bad++; $display("FAIL cls_extra_weight: got wt_ready=%b want 0", wt_ready); end
        wt_valid = 1'b0;
        core_req_img();
        stream(1'b0, IMG_WORDS, 1'b0, xf, vib);
        score_words(ne, ng, nb);
        total++;
        if (xf != IMG_WORDS || ng != ne || nb != 0) begin
            bad++; $display("FAIL cls_img_words: got xfers=%0d rcv=%0d bad=%0d want %0d/%0d/0",
                xf, ng, nb, IMG_WORDS, ne);
        end
        core_result(8'd5, got);
        total++;
        if (!got) begin
            bad++; $display("FAIL cls_res_valid: got none want pulse");
        end else begin
            g = got_res.pop_front();
            if ({g.label, g.match, g.index} !== {8'd5, 1'b0, 16'd0}) begin
                bad++; $display("FAIL cls_result: got %h/%b/%0d want 05/0/0", g.label, g.match, g.index);
            end
        end
        got_res.delete();
        @(negedge clk);
        #1;
        total++;
        if (done !== 1'b1 || start_cnt - s0 != 1) begin
            bad++; $display("FAIL cls_done_start: got done=%b starts=%0d want 1/1", done, start_cnt - s0);
        end
    endtask

    task automatic test_backpressure();
        int xf, ne, ng, nb;
        bit rdy, st, got, vib;
        res_t g;
        issue_cmd(2'd1, 8'd9, 16'd1, rdy, st);
        core_req_img();
        stream(1'b0, IMG_WORDS, 1'b1, xf, vib);
        score_words(ne, ng, nb);
        total++;
        if (xf != IMG_WORDS || ng != ne || nb != 0) begin
            bad++; $display("FAIL bp_img_words: got xfers=%0d rcv=%0d bad=%0d want %0d/%0d/0",
                xf, ng, nb, IMG_WORDS, ne);
        end
        core_result(8'd9, got);
        total++;
        if (!got) begin
            bad++; $display("FAIL bp_res_valid: got none want pulse");
        end else begin
            g = got_res.pop_front();
            if ({g.label, g.match, g.index} !== {8'd9, 1'b1, 16'd0}) begin
                bad++; $display("FAIL bp_result: got %h/%b/%0d want 09/1/0", g.label, g.match, g.index);
            end
        end
        got_res.delete();
        @(negedge clk);
        #1;
        total++;
        if (done !== 1'b1 || correct_cnt !== 16'd1) begin
            bad++; $display("FAIL bp_done_cnt: got done=%b cnt=%0d want 1/1", done, correct_cnt);
        end
    endtask

    task automatic test_zero_reserved();
        int d0, s0;
        bit rdy, st;
        d0 = done_cnt;
        s0 = start_cnt;
        issue_cmd(2'd1, 8'd3, 16'd0, rdy, st);
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (done_cnt - d0 != 1 || start_cnt - s0 != 0 || st !== 1'b0) begin
            bad++; $display("FAIL zero_count: got done=%0d start=%0d want 1/0", done_cnt - d0, start_cnt - s0);
        end
        total++;
        if ({err_mode, busy} !== 2'b00) begin
            bad++; $display("FAIL zero_flags: got err_mode,busy=%b want 00", {err_mode, busy});
        end
        d0 = done_cnt;
        s0 = start_cnt;
        issue_cmd(2'd3, 8'd0, 16'd5, rdy, st);
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (done_cnt - d0 != 1 || start_cnt - s0 != 0 || st !== 1'b0) begin
            bad++; $display("FAIL rsvd_mode: got done=%0d start=%0d want 1/0", done_cnt - d0, start_cnt - s0);
        end
        total++;
        if (err_mode !== 1'b1) begin bad++; $display("FAIL rsvd_err_mode: got %b want 1", err_mode); end
    endtask

    task automatic test_timeout();
        int d0, r0, xf, ne, ng, nb, cyc;
        bit rdy, st, vib;
        issue_cmd(2'd1, 8'd1, 16'd2, rdy, st);
        total++;
        if (err_mode !== 1'b0) begin bad++; $display("FAIL tmo_err_mode_clear: got %b want 0", err_mode); end
        core_req_img();
        stream(1'b0, IMG_WORDS, 1'b0, xf, vib);
        score_words(ne, ng, nb);
        d0 = done_cnt;
        r0 = res_cnt;
        // Now in the first WAIT_RES cycle; core stays silent
        cyc = 1;
        #1;
        while (!done && cyc < 300) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        total++;
        if (cyc != TIMEOUT_CYC + 1) begin
            bad++; $display("FAIL tmo_done_cycle: got %0d want %0d", cyc, TIMEOUT_CYC + 1);
        end
        total++;
        if (err_timeout !== 1'b1) begin bad++; $display("FAIL tmo_err_flag: got %b want 1", err_timeout); end
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done_cnt - d0 != 1 || res_cnt - r0 != 0 || err_timeout !== 1'b1) begin
            bad++; $display("FAIL tmo_after: got busy=%b done=%0d res=%0d err=%b want 0/1/0/1",
                busy, done_cnt - d0, res_cnt - r0, err_timeout);
        end
    endtask

    task automatic test_reset_mid();
        int d0, xf, ne, ng, nb;
        bit rdy, st, got, vib;
        res_t g;
        d0 = done_cnt;
        issue_cmd(2'd1, 8'd2, 16'd1, rdy, st);
        core_req_img();
        stream(1'b0, 10, 1'b0, xf, vib);
        @(negedge clk);
        img_valid  = 1'b1;
        img_data   = 32'hCAFE_F00D;
        core_ready = 1'b1;
        #1;
        total++;
        if ({busy, img_ready} !== 2'b11) begin
            bad++; $display("FAIL rstmid_pre: got busy,img_ready=%b want 11", {busy, img_ready});
        end
        rst = 1'b1;
        #1;
        total++;
        if ({busy, img_ready, core_valid_image, res_valid, done, cmd_ready} !== 6'b000001) begin
            bad++; $display("FAIL rstmid_outputs: got %b want 000001",
                {busy, img_ready, core_valid_image, res_valid, done, cmd_ready});
        end
        total++;
        if (core_image_in !== 32'd0 || correct_cnt !== 16'd0) begin
            bad++; $display("FAIL rstmid_data: got img=%h cnt=%0d want 0/0", core_image_in, correct_cnt);
        end
        @(negedge clk);
        rst       = 1'b0;
        img_valid = 1'b0;
        exp_words.delete();
        got_words.delete();
        @(negedge clk);
        #1;
        total++;
        if (done_cnt != d0) begin bad++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - d0); end
        issue_cmd(2'd1, 8'd4, 16'd1, rdy, st);
        core_req_img();
        stream(1'b0, IMG_WORDS, 1'b0, xf, vib);
        score_words(ne, ng, nb);
        total++;
        if (xf != IMG_WORDS || ng != ne || nb != 0) begin
            bad++; $display("FAIL rstmid_rerun_words: got xfers=%0d rcv=%0d bad=%0d want %0d/%0d/0",
                xf, ng, nb, IMG_WORDS, ne);
        end
        core_result(8'd4, got);
        total++;
        if (!got) begin
            bad++; $display("FAIL rstmid_res_valid: got none want pulse");
        end else begin
            g = got_res.pop_front();
            if ({g.label, g.match, g.index} !== {8'd4, 1'b1, 16'd0}) begin
                bad++; $display("FAIL rstmid_result: got %h/%b/%0d want 04/1/0", g.label, g.match, g.index);
            end
        end
        got_res.delete();
        @(negedge clk);
        #1;
        total++;
        if (done !== 1'b1 || correct_cnt !== 16'd1 || err_timeout !== 1'b0) begin
            bad++; $display("FAIL rstmid_rerun_done: got done=%b cnt=%0d tmo=%b want 1/1/0",
                done, correct_cnt, err_timeout);
        end
    endtask

    initial begin
        rst                 = 1'b1;
        cmd_valid           = 1'b0;
        cmd_mode            = 2'd0;
        cmd_label           = 8'd0;
        cmd_count           = 16'd0;
        img_data            = 32'd0;
        img_valid           = 1'b0;
        wt_data             = 32'd0;
        wt_valid            = 1'b0;
        core_ready          = 1'b1;
        core_start_core_img = 1'b0;
        core_valid_all      = 1'b0;
        core_image_label    = 8'd0;

        test_reset();
        test_test_run();
        test_classify();
        test_backpressure();
        test_zero_reserved();
        test_timeout();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
